// File: rtl/decoder_sel_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// decoder_seq_pkg
//   Shared types and default sizes for the decoder select sequencer.
//   - seq_state_t : sequencer FSM states (IDLE, SCAN)
//   - SEL_W_DEF   : default select-code width (8 channels)
//   - DWELL_W_DEF : default dwell-time width, in clock cycles
// ---------------------------------------------------------------------------
package decoder_seq_pkg;

    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } seq_state_t;

endpackage : decoder_seq_pkg

// File: rtl/decoder_sel_sequencer_next_chan_finder.sv
// ---------------------------------------------------------------------------
// next_chan_finder
//   Combinational search for the next enabled channel in a scan mask.
//   Ports:
//     mask    in  N      channel enable mask (N = 2**SEL_W)
//     cur     in  SEL_W  channel currently selected
//     first   in  1      1: return the lowest set bit, ignoring cur
//     nxt     out SEL_W  next channel to select
//     found   out 1      mask has at least one bit set
//     wrapped out 1      no set bit above cur; nxt is the lowest set bit
// ---------------------------------------------------------------------------
module next_chan_finder
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    localparam int N    = 1 << SEL_W
) (
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             found,
    output logic             wrapped
);

    logic [SEL_W-1:0] lo_idx;
    logic             lo_hit;
    logic [SEL_W-1:0] up_idx;
    logic             up_hit;

    // Two priority scans in one ascending loop: the lowest set bit overall,
    // and the lowest set bit strictly above cur.
    always_comb begin
        // NOTE: combinational logic uses blocking '='; every variable gets a
        // default first so no path leaves it unassigned (no inferred latch).
        lo_idx = '0;
        lo_hit = 1'b0;
        up_idx = '0;
        up_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !lo_hit) begin
                lo_idx = SEL_W'(i);
                lo_hit = 1'b1;
            end
            if (mask[i] && !up_hit && (i > int'(cur))) begin
                up_idx = SEL_W'(i);
                up_hit = 1'b1;
            end
        end
    end

    always_comb begin
        found   = lo_hit;
        wrapped = !first && !up_hit;
        nxt     = (first || !up_hit) ? lo_idx : up_idx;
    end

endmodule : next_chan_finder

// File: rtl/decoder_sel_sequencer.sv
// ---------------------------------------------------------------------------
// decoder_sel_sequencer
//   Generates the select code for a downstream 3-to-8 decoder. On an accepted
//   start it latches the channel mask and dwell time, then visits each enabled
//   channel in ascending order, holding it for max(dwell,1) cycles. Single-pass
//   mode ends with a done pulse; continuous mode wraps to the lowest channel.
//   Ports:
//     clk       in   1        rising-edge clock
//     rst       in   1        asynchronous active-high reset
//     start     in   1        begin a scan (ignored while busy)
//     stop      in   1        abort; return to IDLE at the next edge
//     mode      in   1        0 = single pass, 1 = continuous
//     chan_en   in   N        channel enable mask, latched at start
//     dwell     in   DWELL_W  cycles per channel, latched at start (0 acts as 1)
//     sel       out  SEL_W    select code to the decoder
//     sel_valid out  1        sel is active; gates the decoder
//     busy      out  1        sequencer is scanning
//     done      out  1        1-cycle pulse at the end of a single pass
//     err       out  1        1-cycle pulse: start with an empty mask
// ---------------------------------------------------------------------------
module decoder_sel_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    localparam int N      = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [N-1:0]       chan_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    seq_state_t         state_q,     state_d;
    logic [SEL_W-1:0]   sel_q,       sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;
    logic [DWELL_W-1:0] cnt_q,       cnt_d;
    logic [N-1:0]       mask_q,      mask_d;
    logic [DWELL_W-1:0] reload_q,    reload_d;

    // Counter reload value: a channel is held reload+1 cycles, so dwell=0
    // and dwell=1 both give a one-cycle hold.
    logic [DWELL_W-1:0] dwell_reload;
    assign dwell_reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // -----------------------------------------------------------------------
    // Next-channel search. In IDLE it looks at the live mask (the one about
    // to be latched); while scanning it uses the latched mask.
    // -----------------------------------------------------------------------
    logic             in_idle;
    logic [SEL_W-1:0] fnd_nxt;
    logic             fnd_found;
    logic             fnd_wrapped;

    assign in_idle = (state_q == IDLE);

    next_chan_finder #(
        .SEL_W (SEL_W)
    ) u_finder (
        .mask    (in_idle ? chan_en : mask_q),
        .cur     (sel_q),
        .first   (in_idle),
        .nxt     (fnd_nxt),
        .found   (fnd_found),
        .wrapped (fnd_wrapped)
    );

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        reload_d    = reload_q;

        unique case (state_q)
            IDLE: begin
                // stop outranks start when both arrive in IDLE.
                if (start && !stop) begin
                    if (fnd_found) begin
                        mask_d      = chan_en;
                        reload_d    = dwell_reload;
                        cnt_d       = dwell_reload;
                        sel_d       = fnd_nxt;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SCAN: begin
                if (stop) begin
                    // Abort outranks any advance or end-of-pass this cycle.
                    state_d     = IDLE;
                    sel_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!fnd_wrapped || mode) begin
                    // Next channel above, or wrap to the lowest in continuous
                    // mode (a lone channel simply reloads in place).
                    sel_d = fnd_nxt;
                    cnt_d = reload_q;
                end else begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: the mask and dwell latches are ordinary flops, so they are reset
    // along with everything else; no register is left uninitialised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= '0;
            reload_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            reload_q    <= reload_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule : decoder_sel_sequencer

// File: tb/tb_decoder_sel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_decoder_sel_sequencer
//   Self-checking bench for decoder_sel_sequencer. Expected select traces are
//   built as plain lists: each enabled channel, ascending, repeated
//   max(dwell,1) times per pass. Outputs are sampled 1 ns after each edge.
// ---------------------------------------------------------------------------
module tb_decoder_sel_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] chan_en;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       err;

    int n_pass;
    int n_total;

    decoder_sel_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .chan_en   (chan_en),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: {sel, sel_valid, busy, done, err}
    logic [6:0] obs;
    assign obs = {sel, sel_valid, busy, done, err};

    function automatic logic [6:0] vec(input int s, input bit v, input bit b,
                                       input bit dn, input bit e);
        logic [2:0] s3;
        s3 = 3'(s);
        return {s3, v, b, dn, e};
    endfunction

    // One pass of the scan as a list of select codes, one entry per cycle.
    function automatic void build_pass(input logic [7:0] m, input logic [7:0] d,
                                       output int q[$]);
        int reps;
        q = {};
        reps = (d == 0) ? 1 : int'(d);
        for (int ch = 0; ch < 8; ch++)
            if (m[ch])
                for (int r = 0; r < reps; r++) q.push_back(ch);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a scan and follow it cycle by cycle. stop_at >= 0 aborts after
    // that many checked cycles; noise scrambles chan_en/dwell and pulses
    // start while busy, none of which may disturb the scan.
    task automatic run_scan(input string name, input logic [7:0] m,
                            input logic [7:0] d, input logic md,
                            input int stop_at, input bit noise);
        int pass_q[$];
        int exp_q[$];
        bit stopped;
        build_pass(m, d, pass_q);
        exp_q = pass_q;
        if (md)
            while (exp_q.size() <= stop_at) exp_q = {exp_q, pass_q};
        stopped = 0;

        chan_en = m;
        dwell   = d;
        mode    = md;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_total++;
            if (obs !== vec(exp_q[k], 1, 1, 0, 0))
                $display("FAIL %s cyc%0d got=%b exp=%b", name, k, obs,
                         vec(exp_q[k], 1, 1, 0, 0));
            else n_pass++;
            if (k == stop_at) begin
                stop    = 1'b1;
                stopped = 1;
                break;
            end
            if (noise) begin
                chan_en = 8'($urandom);
                dwell   = 8'($urandom);
                start   = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        if (stopped) begin
            tick();
            stop  = 1'b0;
            start = 1'b0;
            n_total++;
            if (obs !== vec(0, 0, 0, 0, 0))
                $display("FAIL %s_stop got=%b exp=%b", name, obs, vec(0, 0, 0, 0, 0));
            else n_pass++;
        end else begin
            start = 1'b0;
            n_total++;
            if (obs !== vec(0, 0, 0, 1, 0))
                $display("FAIL %s_done got=%b exp=%b", name, obs, vec(0, 0, 0, 1, 0));
            else n_pass++;
        end
        tick();
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL %s_idle got=%b exp=%b", name, obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        chan_en = '0; dwell = '0;
        #2;
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL reset_async got=%b exp=%b", obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL reset_idle got=%b exp=%b", obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_full_single_pass();
        run_scan("full_pass", 8'hFF, 8'd1, 1'b0, -1, 0);
    endtask

    task automatic test_continuous();
        // 2,2,2,5,5,5,7,7,7 then wrap; follow 2.5 passes, then stop.
        run_scan("cont_a4", 8'b1010_0100, 8'd3, 1'b1, 22, 1);
        run_scan("cont_one", 8'b0001_0000, 8'd2, 1'b1, 7, 1);
    endtask

    task automatic test_err();
        chan_en = 8'h00;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 1))
            $display("FAIL err_pulse got=%b exp=%b", obs, vec(0, 0, 0, 0, 1));
        else n_pass++;
        tick();
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL err_clear got=%b exp=%b", obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_dwell_zero();
        run_scan("dwell0_81", 8'h81, 8'd0, 1'b0, -1, 0);
    endtask

    task automatic test_stop();
        // 8'hFF with dwell 4: sel=4 occupies cycles 16..19; stop at 17.
        run_scan("stop_at4", 8'hFF, 8'd4, 1'b0, 17, 1);
        // stop and start together in IDLE: stop wins.
        chan_en = 8'hFF;
        dwell   = 8'd1;
        start   = 1'b1;
        stop    = 1'b1;
        tick();
        start   = 1'b0;
        stop    = 1'b0;
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL stop_start_idle got=%b exp=%b", obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_mode_live();
        // Continuous start; mode drops during the second pass, so the scan
        // wraps once and ends with done after the second pass.
        int pass_q[$];
        int len;
        logic [7:0] m;
        logic [7:0] d;
        m = 8'($urandom_range(1, 255));
        d = 8'($urandom_range(0, 3));
        build_pass(m, d, pass_q);
        len = pass_q.size();
        chan_en = m;
        dwell   = d;
        mode    = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 2 * len; k++) begin
            n_total++;
            if (obs !== vec(pass_q[k % len], 1, 1, 0, 0))
                $display("FAIL mode_live cyc%0d got=%b exp=%b", k, obs,
                         vec(pass_q[k % len], 1, 1, 0, 0));
            else n_pass++;
            if (k == len) mode = 1'b0;
            tick();
        end
        n_total++;
        if (obs !== vec(0, 0, 0, 1, 0))
            $display("FAIL mode_live_done got=%b exp=%b", obs, vec(0, 0, 0, 1, 0));
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        chan_en = 8'hFF;
        dwell   = 8'd5;
        mode    = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL async_rst got=%b exp=%b", obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_total++;
        if (obs !== vec(0, 0, 0, 0, 0))
            $display("FAIL async_rst_idle got=%b exp=%b", obs, vec(0, 0, 0, 0, 0));
        else n_pass++;
        run_scan("after_rst", 8'b0110_0011, 8'd2, 1'b0, -1, 0);
    endtask

    task automatic test_random();
        logic [7:0] m;
        logic [7:0] d;
        logic       md;
        int         sa;
        for (int i = 0; i < 16; i++) begin
            m  = 8'($urandom_range(1, 255));
            d  = 8'($urandom_range(0, 4));
            md = 1'($urandom_range(0, 1));
            sa = md ? $urandom_range(0, 40)
                    : (($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1);
            run_scan($sformatf("rand%0d", i), m, d, md, sa, 1);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_full_single_pass();
        test_continuous();
        test_err();
        test_dwell_zero();
        test_stop();
        test_mode_live();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_decoder_sel_sequencer
